// File: rtl/fma16_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : fma16_result_stage
// Purpose  : Registered output stage for the fma16 datapath. Completed
//            half-precision results and their {NV,OF,UF,NX} flags are queued
//            in a small circular FIFO and presented on a valid/ready
//            handshake. Retired flags accumulate into a sticky fflags
//            register and a saturating counter tracks retirements.
// Ports    : clk, reset                 - clock, async active-high reset
//            in_valid/in_ready          - upstream handshake (in_ready = ~full)
//            in_result/in_flags/in_special - captured only on push
//            out_valid/out_ready        - downstream handshake
//            out_result/out_flags/out_special - head entry, zero when idle
//            fflags, fflags_clr         - sticky retired flags, sync clear
//            retire_cnt                 - saturating retire counter
// Revision : 1.0 - initial release
// ============================================================================
module fma16_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_result,
    input  logic [3:0]      in_flags,
    input  logic            in_special,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_result,
    output logic [3:0]      out_flags,
    output logic            out_special,
    output logic [3:0]      fflags,
    input  logic            fflags_clr,
    output logic [CNTW-1:0] retire_cnt
);

    localparam int            c_PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTRW:0] c_FULL = (c_PTRW+1)'(DEPTH);

    // Entry layout: {special, flags[3:0], result[15:0]}
    logic [20:0]       r_mem [DEPTH];
    logic [c_PTRW-1:0] r_wrPtr;
    logic [c_PTRW-1:0] r_rdPtr;
    logic [c_PTRW:0]   r_count;
    logic [3:0]        r_fflags;
    logic [CNTW-1:0]   r_retireCnt;

    logic              w_push;
    logic              w_pop;
    logic [20:0]       w_head;
    logic              w_headNan;

    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_head    = r_mem[r_rdPtr];

    // Any NaN (exponent all ones, nonzero mantissa) leaves as the canonical
    // quiet NaN; infinities keep their sign and pass unchanged.
    assign w_headNan = (&w_head[14:10]) & (|w_head[9:0]);

    assign out_result  = !out_valid ? 16'h0000 : (w_headNan ? 16'h7e00 : w_head[15:0]);
    assign out_flags   = out_valid ? w_head[19:16] : 4'h0;
    assign out_special = out_valid ? w_head[20]    : 1'b0;
    assign fflags      = r_fflags;
    assign retire_cnt  = r_retireCnt;

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {in_special, in_flags, in_result};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_fflags    <= 4'h0;
            r_retireCnt <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTRW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTRW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end

            // Clear applies to the old value only, so a same-cycle retire
            // still lands its flags.
            r_fflags <= (fflags_clr ? 4'h0 : r_fflags) | (w_pop ? w_head[19:16] : 4'h0);

            if (w_pop && (r_retireCnt != '1)) begin
                r_retireCnt <= r_retireCnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fma16_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fma16_result_stage
// Purpose  : Directed self-checking bench for fma16_result_stage (DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fma16_result_stage;

    localparam int c_DEPTH = 2;
    localparam int c_CNTW  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_result;
    logic [3:0]        in_flags;
    logic              in_special;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_result;
    logic [3:0]        out_flags;
    logic              out_special;
    logic [3:0]        fflags;
    logic              fflags_clr;
    logic [c_CNTW-1:0] retire_cnt;

    int vectors = 0;
    int miscompares = 0;

    fma16_result_stage #(.DEPTH(c_DEPTH), .CNTW(c_CNTW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .in_special (in_special),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_special(out_special),
        .fflags     (fflags),
        .fflags_clr (fflags_clr),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] q [$];
        logic [15:0] nextData;
        int          mCount;
        int          expRetire;
        logic        doPush;
        logic        doPop;

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_result  = 16'h0000;
        in_flags   = 4'h0;
        in_special = 1'b0;
        out_ready  = 1'b0;
        fflags_clr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_fflags", fflags, 4'h0);
        chk("rst_retire", retire_cnt, 16'd0);
        chk("rst_out_result", out_result, 16'h0000);

        // 1: single push, one-cycle latency, then retire
        in_valid = 1'b1; in_result = 16'h3c00; in_flags = 4'h0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", out_valid, 1'b1);
        chk("t1_out_result", out_result, 16'h3c00);
        tick();
        chk("t1_fflags", fflags, 4'h0);
        chk("t1_retire", retire_cnt, 16'd1);
        chk("t1_out_valid_after", out_valid, 1'b0);
        chk("t1_idle_result", out_result, 16'h0000);

        // 2: backpressure fills the FIFO, third push held upstream
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 16'h4000;
        tick();
        in_result = 16'h4200;
        tick();
        in_result = 16'h4400;
        chk("t2_full_in_ready", in_ready, 1'b0);
        chk("t2_head0", out_result, 16'h4000);
        tick();
        chk("t2_head_stable", out_result, 16'h4000);
        chk("t2_still_full", in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("t2_head1", out_result, 16'h4200);
        chk("t2_ready_again", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t2_head2", out_result, 16'h4400);
        tick();
        chk("t2_empty", out_valid, 1'b0);
        chk("t2_retire", retire_cnt, 16'd4);

        // 3: NaN canonicalisation, infinity pass-through, sticky flags
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 16'h7c01; in_flags = 4'b1000; in_special = 1'b1;
        tick();
        in_valid = 1'b0; in_special = 1'b0;
        chk("t3_nan_result", out_result, 16'h7e00);
        chk("t3_nan_flags", out_flags, 4'b1000);
        chk("t3_special", out_special, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("t3_fflags_nv", fflags, 4'b1000);
        in_valid = 1'b1; in_result = 16'h7c00; in_flags = 4'b0101;
        tick();
        in_valid = 1'b0;
        chk("t3_inf_result", out_result, 16'h7c00);
        chk("t3_inf_flags", out_flags, 4'b0101);
        chk("t3_inf_special", out_special, 1'b0);
        tick();
        chk("t3_fflags_acc", fflags, 4'b1101);
        in_valid = 1'b1; in_result = 16'hfe01; in_flags = 4'h0; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("t3_neg_nan", out_result, 16'h7e00);
        out_ready = 1'b1;
        tick();

        // 4: clear concurrent with a retire keeps only the retiring flags
        out_ready = 1'b0; fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        chk("t4_cleared", fflags, 4'h0);
        in_valid = 1'b1; in_result = 16'h1111; in_flags = 4'b1001;
        tick();
        in_result = 16'h2222; in_flags = 4'b0001;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("t4_fflags_9", fflags, 4'b1001);
        fflags_clr = 1'b1;
        tick();
        chk("t4_clr_and_pop", fflags, 4'b0001);
        tick();
        fflags_clr = 1'b0;
        chk("t4_clr_alone", fflags, 4'h0);
        chk("t4_retire", retire_cnt, 16'd9);

        // 5: streaming through a full FIFO for 20 cycles, scoreboard order
        expRetire = 9;
        mCount = 0;
        nextData = 16'h0a00;
        in_flags = 4'b0010;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < c_DEPTH; i++) begin
            in_result = nextData;
            tick();
            q.push_back(nextData);
            nextData++;
            mCount++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_result = nextData;
            doPush = (mCount < c_DEPTH);
            doPop  = (mCount > 0);
            chk("t5_in_ready", in_ready, doPush);
            chk("t5_head", out_result, q[0]);
            tick();
            if (doPop) begin
                void'(q.pop_front());
                mCount--;
                expRetire++;
            end
            if (doPush) begin
                q.push_back(nextData);
                nextData++;
                mCount++;
            end
        end
        in_valid = 1'b0;
        chk("t5_retire", retire_cnt, expRetire[15:0]);
        chk("t5_fflags", fflags, 4'b0010);

        // 6: asynchronous reset between edges with two entries queued
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = nextData;
        tick();
        in_valid = 1'b0;
        chk("t6_full", in_ready, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_rst_out_valid", out_valid, 1'b0);
        chk("t6_rst_fflags", fflags, 4'h0);
        chk("t6_rst_retire", retire_cnt, 16'd0);
        chk("t6_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        tick();
        in_valid = 1'b1; in_result = 16'h1234; in_flags = 4'h0;
        tick();
        in_valid = 1'b0;
        chk("t6_new_valid", out_valid, 1'b1);
        chk("t6_new_result", out_result, 16'h1234);
        chk("t6_one_entry", in_ready, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("t6_no_stale", out_valid, 1'b0);
        chk("t6_retire", retire_cnt, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fma16_result_stage.md
Name: fma16_result_stage

Overview:
Registered output stage directly downstream of the fma16 special-case/rounding logic. It captures each completed half-precision result and its 4-bit exception flags into a small FIFO and presents them on a valid/ready handshake. On retirement it accumulates the flags into a sticky fflags register and keeps a saturating retire counter. It decouples the combinational datapath from a stalling consumer such as a testbench checker or a writeback port.

Parameters:
DEPTH, 2, FIFO entries; power of two, 2..8.
CNTW, 16, width of the retire counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream presents a result this cycle.
in_ready  output  1  stage can accept; equals ~full.
in_result  input  16  half-precision result from the special-case stage.
in_flags  input  4  {NV, OF, UF, NX} from the special-case stage.
in_special  input  1  result came from a special-case path.
out_valid  output  1  head entry valid.
out_ready  input  1  consumer accepts the head entry.
out_result  output  16  head result; any NaN is canonicalised to 16'h7e00.
out_flags  output  4  head flags.
out_special  output  1  head special-case bit.
fflags  output  4  sticky OR of retired flags.
fflags_clr  input  1  synchronous clear of fflags.
retire_cnt  output  CNTW  number of retired entries, saturating.

Behaviour:
- Reset (async assert, sync release): FIFO empty, rd/wr pointers 0, count 0, fflags 4'h0, retire_cnt 0, out_valid 0, in_ready 1.
- Outputs out_result, out_flags and out_special are 0 whenever out_valid is 0.
- Storage is a DEPTH-entry circular buffer of 21 bits per entry: {special, flags, result}.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- Push occurs when in_valid & in_ready. The entry is written at wr_ptr and wr_ptr increments.
- Pop occurs when out_valid & out_ready. rd_ptr increments.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1. There is no combinational in->out path.
- in_ready depends only on count, never on out_ready. Push while full is blocked; data is held upstream.
- Simultaneous push and pop when full: the pop proceeds and the push is refused (in_ready = 0). Count goes to DEPTH-1.
- Simultaneous push and pop when 0 < count < DEPTH: both proceed and count is unchanged.
- Pop when empty: impossible because out_valid = 0; out_ready is ignored.
- out_valid = (count != 0). out_* are driven from the entry at rd_ptr.
- The consumer may deassert out_ready at any time. The head entry stays stable until popped.
- NaN canonicalisation: if head result[14:10] == 5'h1f and result[9:0] != 0, out_result = 16'h7e00. out_flags is unchanged. Infinities (mantissa 0) pass through unchanged.
- fflags next value = (fflags_clr ? 4'h0 : fflags) | (pop ? head_flags : 4'h0). A clear and a retire in the same cycle leave exactly the retiring flags.
- retire_cnt increments on each pop and saturates at all-ones. fflags_clr does not affect it.
- Reset asserted mid-operation discards all entries immediately, including any push accepted in that cycle.
- in_valid must not depend on in_ready. Inputs are sampled only on push.

Test Plan:
1. Reset, then push in_result=16'h3c00, in_flags=4'h0 with out_ready=1 -> next cycle out_valid=1, out_result=16'h3c00. After that pop: fflags=0, retire_cnt=1, out_valid=0.
2. Hold out_ready=0 and push 3 results (16'h4000, 16'h4200, 16'h4400) with DEPTH=2 -> first two accepted, in_ready=0 on the third. Raise out_ready -> pops in order 4000, 4200. The third is then accepted and emerges as 4400.
3. Push in_result=16'h7c01, flags=4'b1000 -> out_result=16'h7e00, out_flags=4'b1000. After pop, fflags=4'b1000. Push 16'h7c00, flags 4'b0101 -> out_result=16'h7c00, fflags=4'b1101.
4. Set fflags=4'b1001, then in one cycle assert fflags_clr while popping an entry with flags 4'b0001 -> fflags=4'b0001. The next cycle, fflags_clr alone -> 4'h0.
5. Full FIFO with in_valid=1 and out_ready=1 for 20 consecutive cycles -> one entry retires per cycle, data order is preserved, and pointer wrap is correct (scoreboard compare). retire_cnt advances by 20.
6. Assert reset asynchronously (between edges) with 2 entries queued -> out_valid=0, fflags=0 and retire_cnt=0 immediately. After release, a new push emerges one cycle later with no stale data.
